// File: rtl/fixed_linear_tiled.sv
// fixed_linear_tiled
//   Streaming fixed-point linear layer. Each window takes IN_DEPTH beats of
//   IN_SIZE signed inputs. A beat is accumulated against IN_SIZE*PARALLELISM
//   signed weights into wide per-lane accumulators. When HAS_BIAS is set, a
//   per-lane bias is added once per window. The sum is then rounded half-up
//   and saturated to OUT_WIDTH/OUT_FRAC_WIDTH, giving one output beat per
//   window.
//
// Ports
//   clk                                    clock
//   rst                                    synchronous reset, active low
//   data_in / data_in_valid / data_in_ready        input beat (element k at bits k*IN_WIDTH)
//   weight / weight_valid / weight_ready           weights, lane-major (lane i, element k at i*IN_SIZE+k)
//   bias / bias_valid / bias_ready                 per-lane bias
//   data_out / data_out_valid / data_out_ready     registered result (lane i at bits i*OUT_WIDTH)
//   sat_flag                               some lane was clipped; qualified by data_out_valid
//
// Build option
//   FIXED_LINEAR_TILED_RELU_EN : when defined, negative lanes are forced to 0
//   after saturation. sat_flag is not affected by this clamp.
//
// State   | meaning
// --------+------------------------------------------------------------
// S_ACCUM | joining data/weight beats into the accumulators
// S_BIAS  | all beats are in; waiting for the bias beat
// S_OUT   | result is held on data_out until the consumer takes it

module fixed_linear_tiled #(
  parameter int IN_WIDTH          = 8,
  parameter int IN_FRAC_WIDTH     = 4,
  parameter int WEIGHT_WIDTH      = 8,
  parameter int WEIGHT_FRAC_WIDTH = 4,
  parameter int IN_SIZE           = 4,
  parameter int IN_DEPTH          = 3,
  parameter int PARALLELISM       = 2,
  parameter int HAS_BIAS          = 1,
  parameter int BIAS_WIDTH        = 8,
  parameter int BIAS_FRAC_WIDTH   = 4,
  parameter int OUT_WIDTH         = 8,
  parameter int OUT_FRAC_WIDTH    = 4
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [IN_WIDTH*IN_SIZE-1:0]                 data_in,
  input  logic                                        data_in_valid,
  output logic                                        data_in_ready,
  input  logic [WEIGHT_WIDTH*IN_SIZE*PARALLELISM-1:0] weight,
  input  logic                                        weight_valid,
  output logic                                        weight_ready,
  input  logic [BIAS_WIDTH*PARALLELISM-1:0]           bias,
  input  logic                                        bias_valid,
  output logic                                        bias_ready,
  output logic [OUT_WIDTH*PARALLELISM-1:0]            data_out,
  output logic                                        data_out_valid,
  input  logic                                        data_out_ready,
  output logic                                        sat_flag
);

  localparam int ACC_WIDTH = IN_WIDTH + WEIGHT_WIDTH + $clog2(IN_SIZE) + $clog2(IN_DEPTH) + 1;
  localparam int PF        = IN_FRAC_WIDTH + WEIGHT_FRAC_WIDTH;
  localparam int PROD_W    = IN_WIDTH + WEIGHT_WIDTH;
  localparam int CNT_W     = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(IN_DEPTH - 1);

  // Bias alignment to the product binary point.
  localparam int BSH      = PF - BIAS_FRAC_WIDTH;
  localparam int BIAS_LSH = (BSH > 0) ? BSH : 0;
  localparam int BIAS_RSH = (BSH < 0) ? -BSH : 0;

  // Output cast: a right shift with round-half-up, or a plain left shift.
  localparam int SHIFT  = PF - OUT_FRAC_WIDTH;
  localparam int RSH    = (SHIFT > 0) ? SHIFT : 0;
  localparam int LSH    = (SHIFT < 0) ? -SHIFT : 0;
  localparam int RSH_M1 = (RSH > 0) ? RSH - 1 : 0;
  // One extra bit so that adding the rounding constant cannot wrap.
  localparam int EXT_W  = ACC_WIDTH + 1 + LSH;
  localparam logic signed [EXT_W-1:0] ROUND_C = (RSH > 0) ? EXT_W'(64'sd1 <<< RSH_M1) : '0;
  localparam logic signed [EXT_W-1:0] OUT_MAX = EXT_W'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
  localparam logic signed [EXT_W-1:0] OUT_MIN = ~OUT_MAX;

  typedef enum logic [1:0] {S_ACCUM, S_BIAS, S_OUT} state_t;

  state_t                        state;
  logic [CNT_W-1:0]              beat_cnt;
  logic signed [ACC_WIDTH-1:0]   acc       [PARALLELISM];
  logic signed [ACC_WIDTH-1:0]   final_acc [PARALLELISM];
  logic signed [ACC_WIDTH-1:0]   beat_sum;
  logic signed [ACC_WIDTH-1:0]   bias_ext;
  logic signed [PROD_W-1:0]      prod;
  logic signed [EXT_W-1:0]       ext;
  logic [OUT_WIDTH*PARALLELISM-1:0] out_next;
  logic                          sat_next;
  logic                          beat_fire;

  // Data and weight are joined: each ready mirrors the other valid.
  assign data_in_ready = rst && (state == S_ACCUM) && weight_valid;
  assign weight_ready  = rst && (state == S_ACCUM) && data_in_valid;
  assign bias_ready    = rst && ((HAS_BIAS == 0) || (state == S_BIAS));
  assign beat_fire     = (state == S_ACCUM) && data_in_valid && weight_valid;

  // Next accumulator value (beat or bias), followed by the output cast that
  // is computed from it.
  always_comb begin
    sat_next = 1'b0;
    out_next = '0;
    prod     = '0;
    beat_sum = '0;
    bias_ext = '0;
    ext      = '0;
    for (int i = 0; i < PARALLELISM; i++) begin
      beat_sum = '0;
      for (int k = 0; k < IN_SIZE; k++) begin
        prod     = $signed(data_in[k*IN_WIDTH +: IN_WIDTH]) *
                   $signed(weight[(i*IN_SIZE+k)*WEIGHT_WIDTH +: WEIGHT_WIDTH]);
        beat_sum = beat_sum + ACC_WIDTH'(prod);
      end

      bias_ext = ACC_WIDTH'($signed(bias[i*BIAS_WIDTH +: BIAS_WIDTH]));
      if (BIAS_LSH > 0) bias_ext = bias_ext <<< BIAS_LSH;
      else              bias_ext = bias_ext >>> BIAS_RSH;

      final_acc[i] = (state == S_BIAS) ? acc[i] + bias_ext : acc[i] + beat_sum;

      ext = EXT_W'(final_acc[i]);
      if (RSH > 0) ext = (ext + ROUND_C) >>> RSH;
      else         ext = ext <<< LSH;

      if (ext > OUT_MAX) begin
        ext      = OUT_MAX;
        sat_next = 1'b1;
      end else if (ext < OUT_MIN) begin
        ext      = OUT_MIN;
        sat_next = 1'b1;
      end
`ifdef FIXED_LINEAR_TILED_RELU_EN
      if (ext[EXT_W-1]) ext = '0;
`endif
      out_next[i*OUT_WIDTH +: OUT_WIDTH] = ext[OUT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= S_ACCUM;
      beat_cnt       <= '0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      sat_flag       <= 1'b0;
      for (int i = 0; i < PARALLELISM; i++) acc[i] <= '0;
    end else begin
      case (state)
        S_ACCUM: begin
          if (beat_fire) begin
            for (int i = 0; i < PARALLELISM; i++) acc[i] <= final_acc[i];
            if (beat_cnt == LAST_BEAT) begin
              beat_cnt <= '0;
              if (HAS_BIAS != 0) begin
                state <= S_BIAS;
              end else begin
                data_out       <= out_next;
                sat_flag       <= sat_next;
                data_out_valid <= 1'b1;
                state          <= S_OUT;
              end
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        S_BIAS: begin
          if (bias_valid) begin
            for (int i = 0; i < PARALLELISM; i++) acc[i] <= final_acc[i];
            data_out       <= out_next;
            sat_flag       <= sat_next;
            data_out_valid <= 1'b1;
            state          <= S_OUT;
          end
        end
        S_OUT: begin
          if (data_out_ready) begin
            for (int i = 0; i < PARALLELISM; i++) acc[i] <= '0;
            data_out_valid <= 1'b0;
            state          <= S_ACCUM;
          end
        end
        default: state <= S_ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_linear_tiled.sv
module tb_fixed_linear_tiled;

`ifdef FIXED_LINEAR_TILED_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [31:0] din;
  logic [63:0] wt;
  logic [15:0] bs;

  logic        nb_din_v, nb_wt_v, nb_bias_v, nb_dout_rdy;
  logic        nb_din_rdy, nb_wt_rdy, nb_bias_rdy, nb_dout_v, nb_sat;
  logic [15:0] nb_dout;
  logic        b_din_v, b_wt_v, b_bias_v, b_dout_rdy;
  logic        b_din_rdy, b_wt_rdy, b_bias_rdy, b_dout_v, b_sat;
  logic [15:0] b_dout;

  int n_vec = 0;
  int n_err = 0;

  fixed_linear_tiled #(.HAS_BIAS(0)) u_nb (
    .clk(clk), .rst(rst),
    .data_in(din), .data_in_valid(nb_din_v), .data_in_ready(nb_din_rdy),
    .weight(wt), .weight_valid(nb_wt_v), .weight_ready(nb_wt_rdy),
    .bias(bs), .bias_valid(nb_bias_v), .bias_ready(nb_bias_rdy),
    .data_out(nb_dout), .data_out_valid(nb_dout_v), .data_out_ready(nb_dout_rdy),
    .sat_flag(nb_sat)
  );

  fixed_linear_tiled #(.HAS_BIAS(1)) u_b (
    .clk(clk), .rst(rst),
    .data_in(din), .data_in_valid(b_din_v), .data_in_ready(b_din_rdy),
    .weight(wt), .weight_valid(b_wt_v), .weight_ready(b_wt_rdy),
    .bias(bs), .bias_valid(b_bias_v), .bias_ready(b_bias_rdy),
    .data_out(b_dout), .data_out_valid(b_dout_v), .data_out_ready(b_dout_rdy),
    .sat_flag(b_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] d;
    logic [63:0] w;
    bit          rep;
    bit          use_bias;
    logic [15:0] b;
    logic [15:0] exp_out;
    bit          exp_sat;
  } vec_t;

  vec_t vecs[9];

  function automatic logic [31:0] pack4(input int a, input int b, input int c, input int d);
    return {d[7:0], c[7:0], b[7:0], a[7:0]};
  endfunction

  function automatic logic [15:0] pack2(input int a, input int b);
    return {b[7:0], a[7:0]};
  endfunction

  function automatic int relu(input int x);
    return (RELU && x < 0) ? 0 : x;
  endfunction

  function automatic logic [15:0] exp2(input int a, input int b);
    return pack2(relu(a), relu(b));
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drop_valids();
    nb_din_v = 0; nb_wt_v = 0; nb_bias_v = 0;
    b_din_v  = 0; b_wt_v  = 0; b_bias_v  = 0;
  endtask

  // Entry and exit are 1 time unit after a rising edge.
  task automatic do_beats(input vec_t v, input int nbeats);
    for (int bt = 0; bt < nbeats; bt++) begin
      din = (bt == 0 || v.rep) ? v.d : '0;
      wt  = (bt == 0 || v.rep) ? v.w : '0;
      if (v.use_bias) begin b_din_v = 1; b_wt_v = 1; end
      else begin nb_din_v = 1; nb_wt_v = 1; end
      @(posedge clk); #1;
    end
    drop_valids();
  endtask

  task automatic apply_vec(input vec_t v, input int hold);
    do_beats(v, 3);
    if (v.use_bias) begin
      for (int h = 0; h < hold; h++) begin
        check({v.name, "_nobias_valid"}, b_dout_v, 0);
        check({v.name, "_bias_ready"}, b_bias_rdy, 1);
        @(posedge clk); #1;
      end
      bs = v.b; b_bias_v = 1;
      @(posedge clk); #1;
      b_bias_v = 0;
      check({v.name, "_valid"}, b_dout_v, 1);
      check({v.name, "_data"}, b_dout, v.exp_out);
      check({v.name, "_sat"}, b_sat, v.exp_sat);
      b_dout_rdy = 1;
      @(posedge clk); #1;
      b_dout_rdy = 0;
      check({v.name, "_pop"}, b_dout_v, 0);
    end else begin
      check({v.name, "_valid"}, nb_dout_v, 1);
      check({v.name, "_data"}, nb_dout, v.exp_out);
      check({v.name, "_sat"}, nb_sat, v.exp_sat);
      nb_dout_rdy = 1;
      @(posedge clk); #1;
      nb_dout_rdy = 0;
      check({v.name, "_pop"}, nb_dout_v, 0);
    end
  endtask

  initial begin
    vecs[0] = '{name:"basic", d:pack4(8,8,8,8), w:{pack4(-8,-8,-8,-8), pack4(8,8,8,8)},
                rep:1, use_bias:0, b:16'h0, exp_out:exp2(48,-48), exp_sat:0};
    vecs[1] = '{name:"sat_full", d:pack4(127,127,127,127),
                w:{pack4(-127,-127,-127,-127), pack4(127,127,127,127)},
                rep:1, use_bias:0, b:16'h0, exp_out:exp2(127,-128), exp_sat:1};
    vecs[2] = '{name:"round_up", d:pack4(1,0,0,0), w:{pack4(7,0,0,0), pack4(8,0,0,0)},
                rep:0, use_bias:0, b:16'h0, exp_out:exp2(1,0), exp_sat:0};
    vecs[3] = '{name:"round_neg", d:pack4(1,0,0,0), w:{pack4(-9,0,0,0), pack4(-8,0,0,0)},
                rep:0, use_bias:0, b:16'h0, exp_out:exp2(0,-1), exp_sat:0};
    vecs[4] = '{name:"mixed", d:pack4(1,2,3,4), w:{pack4(16,0,0,-16), pack4(1,1,1,1)},
                rep:1, use_bias:0, b:16'h0, exp_out:exp2(2,-9), exp_sat:0};
    vecs[5] = '{name:"sat_edge", d:pack4(127,8,0,0), w:{pack4(16,1,0,0), pack4(16,0,0,0)},
                rep:0, use_bias:0, b:16'h0, exp_out:exp2(127,127), exp_sat:1};
    vecs[6] = '{name:"bias_basic", d:pack4(8,8,8,8), w:{pack4(-8,-8,-8,-8), pack4(8,8,8,8)},
                rep:1, use_bias:1, b:pack2(16,-16), exp_out:exp2(64,-64), exp_sat:0};
    vecs[7] = '{name:"bias_only", d:32'h0, w:64'h0,
                rep:1, use_bias:1, b:pack2(-1,5), exp_out:exp2(-1,5), exp_sat:0};
    vecs[8] = '{name:"bias_sat", d:pack4(8,8,8,8), w:{pack4(-8,-8,-8,-8), pack4(8,8,8,8)},
                rep:1, use_bias:1, b:pack2(127,-128), exp_out:exp2(127,-128), exp_sat:1};

    // Reset: readies must stay low even with every valid asserted.
    rst = 0; din = vecs[0].d; wt = vecs[0].w; bs = 16'h0;
    nb_din_v = 1; nb_wt_v = 1; nb_bias_v = 1; b_din_v = 1; b_wt_v = 1; b_bias_v = 1;
    nb_dout_rdy = 0; b_dout_rdy = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_din_ready", nb_din_rdy, 0);
    check("rst_wt_ready", nb_wt_rdy, 0);
    check("rst_bias_ready", b_bias_rdy, 0);
    check("rst_valid_nb", nb_dout_v, 0);
    check("rst_valid_b", b_dout_v, 0);
    check("rst_data_nb", nb_dout, 0);
    check("rst_sat_nb", nb_sat, 0);
    drop_valids();
    rst = 1;
    @(posedge clk); #1;
    check("nobias_bias_ready_const", nb_bias_rdy, 1);
    check("accum_bias_ready_low", b_bias_rdy, 0);

    for (int i = 0; i < 9; i++) apply_vec(vecs[i], 0);

    // Bias held back for 4 cycles: no output until it arrives.
    apply_vec(vecs[6], 4);

    // Backpressure: output held stable, no beat accepted while waiting.
    do_beats(vecs[0], 3);
    din = vecs[0].d; wt = vecs[0].w; nb_din_v = 1; nb_wt_v = 1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("stall_data", nb_dout, exp2(48,-48));
      check("stall_valid", nb_dout_v, 1);
      check("stall_din_ready", nb_din_rdy, 0);
    end
    drop_valids();
    nb_dout_rdy = 1;
    @(posedge clk); #1;
    nb_dout_rdy = 0;
    check("stall_pop", nb_dout_v, 0);
    // Data without weight: nothing is consumed.
    nb_din_v = 1;
    for (int c = 0; c < 3; c++) begin
      check("lone_valid_ready", nb_din_rdy, 0);
      @(posedge clk); #1;
    end
    nb_din_v = 0;
    apply_vec(vecs[0], 0);

    // Reset mid-window discards the partial sums.
    do_beats(vecs[1], 2);
    rst = 0;
    @(posedge clk); #1;
    rst = 1;
    check("midrst_valid", nb_dout_v, 0);
    apply_vec(vecs[0], 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
